mem_arbiter: RTL and testbench

- Arbitrates the CPU's instruction-fetch and data-access requests onto the single shared RAM port.
- Sits between the cache-side requesters (imem/dmem signals of datapath_cache_if) and the RAM model.
- Data requests have priority by default. A starvation counter guarantees forward progress for fetch.
- A watchdog flags a RAM that never completes.

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for instruction fetch and data access.
// Data requests win by default; a starvation counter forces a fetch grant, and a watchdog aborts stuck grants.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        memerr
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] starve_cnt, starve_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt, tmo_inc;
   logic          memerr_nxt;
   logic          tmo_hit;
   logic          access;

   assign access  = (ramstate == RAM_ACCESS);
   assign tmo_inc = tmo_cnt + TW'(1);
   assign tmo_hit = (tmo_inc == TW'(TIMEOUT));

   // State and counter registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         memerr     <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         tmo_cnt    <= tmo_nxt;
         memerr     <= memerr_nxt;
      end
   end

   // Arbitration, RAM muxing and completion handshakes
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      tmo_nxt    = tmo_cnt;
      memerr_nxt = memerr;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      iload      = '0;
      dload      = '0;

      case (state)
         IDLE: begin
            tmo_nxt = '0;
            if (iREN && (starve_cnt == SW'(STARVE_MAX)))
               state_nxt = GRANT_I;
            else if (dREN || dWEN)
               state_nxt = GRANT_D;
            else if (iREN)
               state_nxt = GRANT_I;
         end

         GRANT_D: begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (access) begin
               dwait     = 1'b0;
               dload     = ramload;
               state_nxt = IDLE;
               if (!iREN)
                  starve_nxt = '0;
               else if (starve_cnt != SW'(STARVE_MAX))
                  starve_nxt = starve_cnt + SW'(1);
            end else if (!(dREN || dWEN)) begin
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               memerr_nxt = 1'b1;
               state_nxt  = IDLE;
            end else begin
               tmo_nxt = tmo_inc;
            end
         end

         GRANT_I: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (access) begin
               iwait      = 1'b0;
               iload      = ramload;
               state_nxt  = IDLE;
               starve_nxt = '0;
            end else if (!iREN) begin
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               memerr_nxt = 1'b1;
               state_nxt  = IDLE;
            end else begin
               tmo_nxt = tmo_inc;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change after the falling edge, outputs sampled 1ns later.
module tb_mem_arbiter;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN, memerr;
   logic [1:0]  ramstate;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
   );

   task automatic idle_inputs();
      iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0;
      ramload = 0; ramstate = FREE;
   endtask

   task automatic test_reset();
      nRST = 0;
      idle_inputs();
      #1;
      checks++;
      if ({ramREN, ramWEN, iwait, dwait, memerr} !== 5'b00110) begin
         errors++; $display("FAIL reset_ctl: got %b want %b", {ramREN, ramWEN, iwait, dwait, memerr}, 5'b00110);
      end
      checks++;
      if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
         errors++; $display("FAIL reset_data: got %h want 0", {ramaddr, ramstore, iload, dload});
      end
      @(negedge CLK);
      nRST = 1;
      @(negedge CLK);
   endtask

   task automatic test_fetch();
      iREN = 1; iaddr = 32'h40; ramstate = FREE;
      #1;
      checks++;
      if ({ramREN, iwait} !== 2'b01) begin
         errors++; $display("FAIL fetch_idle: got %b want %b", {ramREN, iwait}, 2'b01);
      end
      @(negedge CLK);
      ramstate = BUSY;
      #1;
      checks++;
      if ({ramREN, ramWEN, iwait, ramaddr} !== {3'b101, 32'h40}) begin
         errors++; $display("FAIL fetch_grant: got %b/%h want 101/00000040", {ramREN, ramWEN, iwait}, ramaddr);
      end
      @(negedge CLK);
      ramstate = ACCESS; ramload = 32'h8C220004;
      #1;
      checks++;
      if ({iwait, iload} !== {1'b0, 32'h8C220004}) begin
         errors++; $display("FAIL fetch_done: got %b/%h want 0/8c220004", iwait, iload);
      end
      @(negedge CLK);
      iREN = 0; ramstate = FREE;
      #1;
      checks++;
      if ({ramREN, iwait, iload} !== {2'b01, 32'h0}) begin
         errors++; $display("FAIL fetch_after: got %b/%b/%h want 0/1/0", ramREN, iwait, iload);
      end
      @(negedge CLK);
   endtask

   task automatic test_simultaneous();
      iREN = 1; iaddr = 32'h44;
      dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = FREE;
      #1;
      checks++;
      if ({ramREN, ramWEN} !== 2'b00) begin
         errors++; $display("FAIL sim_idle: got %b want 00", {ramREN, ramWEN});
      end
      @(negedge CLK);
      ramstate = BUSY;
      #1;
      checks++;
      if ({ramREN, ramWEN, iwait, dwait} !== 4'b0111) begin
         errors++; $display("FAIL sim_dgrant: got %b want 0111", {ramREN, ramWEN, iwait, dwait});
      end
      checks++;
      if ({ramaddr, ramstore} !== {32'h100, 32'hDEADBEEF}) begin
         errors++; $display("FAIL sim_dbus: got %h/%h want 00000100/deadbeef", ramaddr, ramstore);
      end
      @(negedge CLK);
      ramstate = ACCESS; ramload = 32'h12345678;
      #1;
      checks++;
      if ({iwait, dwait, dload} !== {2'b10, 32'h12345678}) begin
         errors++; $display("FAIL sim_ddone: got %b/%h want 10/12345678", {iwait, dwait}, dload);
      end
      @(negedge CLK);
      dWEN = 0; daddr = 0; dstore = 0; ramstate = FREE;
      #1;
      checks++;
      if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
         errors++; $display("FAIL sim_idle2: got %b want 0011", {ramREN, ramWEN, iwait, dwait});
      end
      @(negedge CLK);
      ramstate = ACCESS; ramload = 32'hCAFEF00D;
      #1;
      checks++;
      if ({ramREN, ramWEN, iwait, dwait, ramaddr, iload} !== {4'b1001, 32'h44, 32'hCAFEF00D}) begin
         errors++; $display("FAIL sim_idone: got %b/%h/%h want 1001/00000044/cafef00d",
                            {ramREN, ramWEN, iwait, dwait}, ramaddr, iload);
      end
      @(negedge CLK);
      iREN = 0; ramstate = FREE;
      #1;
      checks++;
      if (iwait !== 1'b1) begin
         errors++; $display("FAIL sim_after: got iwait=%b want 1", iwait);
      end
      @(negedge CLK);
   endtask

   task automatic test_starvation();
      iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
      for (int k = 0; k < 4; k++) begin
         ramstate = FREE;
         #1;
         checks++;
         if (ramREN !== 1'b0) begin
            errors++; $display("FAIL starve_idle%0d: got ramREN=%b want 0", k, ramREN);
         end
         @(negedge CLK);
         ramstate = ACCESS; ramload = 32'(k + 1);
         #1;
         checks++;
         if ({ramREN, iwait, dwait, ramaddr, dload} !== {3'b110, 32'h200, 32'(k + 1)}) begin
            errors++; $display("FAIL starve_d%0d: got %b/%h/%h want 110/00000200/%h",
                               k, {ramREN, iwait, dwait}, ramaddr, dload, 32'(k + 1));
         end
         @(negedge CLK);
      end
      ramstate = FREE;
      #1;
      checks++;
      if (int'(dut.starve_cnt) != 4) begin
         errors++; $display("FAIL starve_cnt_max: got %0d want 4", dut.starve_cnt);
      end
      @(negedge CLK);
      ramstate = ACCESS; ramload = 32'hFACE0001;
      #1;
      checks++;
      if ({ramREN, iwait, dwait, ramaddr, iload} !== {3'b101, 32'h80, 32'hFACE0001}) begin
         errors++; $display("FAIL starve_forced_i: got %b/%h/%h want 101/00000080/face0001",
                            {ramREN, iwait, dwait}, ramaddr, iload);
      end
      @(negedge CLK);
      iREN = 0; dREN = 0; ramstate = FREE;
      #1;
      checks++;
      if (int'(dut.starve_cnt) != 0) begin
         errors++; $display("FAIL starve_cnt_clr: got %0d want 0", dut.starve_cnt);
      end
      @(negedge CLK);
   endtask

   task automatic test_abort();
      dREN = 1; daddr = 32'h400; iREN = 1; iaddr = 32'h84; ramstate = FREE;
      #1;
      @(negedge CLK);
      ramstate = BUSY;
      #1;
      checks++;
      if ({ramREN, dwait, ramaddr} !== {2'b11, 32'h400}) begin
         errors++; $display("FAIL abort_grant: got %b/%h want 11/00000400", {ramREN, dwait}, ramaddr);
      end
      @(negedge CLK);
      dREN = 0;
      #1;
      checks++;
      if ({ramREN, iwait, dwait, ramaddr} !== {3'b011, 32'h400}) begin
         errors++; $display("FAIL abort_drop: got %b/%h want 011/00000400", {ramREN, iwait, dwait}, ramaddr);
      end
      @(negedge CLK);
      #1;
      checks++;
      if ({ramREN, iwait, dwait, ramaddr} !== {3'b011, 32'h0}) begin
         errors++; $display("FAIL abort_idle: got %b/%h want 011/00000000", {ramREN, iwait, dwait}, ramaddr);
      end
      @(negedge CLK);
      ramstate = ACCESS; ramload = 32'h0BADC0DE;
      #1;
      checks++;
      if ({ramREN, iwait, dwait, ramaddr, iload} !== {3'b101, 32'h84, 32'h0BADC0DE}) begin
         errors++; $display("FAIL abort_ifetch: got %b/%h/%h want 101/00000084/0badc0de",
                            {ramREN, iwait, dwait}, ramaddr, iload);
      end
      @(negedge CLK);
      iREN = 0; ramstate = FREE;
      @(negedge CLK);
   endtask

   task automatic test_watchdog();
      dREN = 1; daddr = 32'h300; ramstate = BUSY;
      #1;
      @(negedge CLK);
      for (int k = 0; k < 8; k++) begin
         #1;
         checks++;
         if ({ramREN, memerr} !== 2'b10) begin
            errors++; $display("FAIL wdog_wait%0d: got %b want 10", k, {ramREN, memerr});
         end
         @(negedge CLK);
      end
      dREN = 0; ramstate = FREE;
      #1;
      checks++;
      if ({ramREN, dwait, memerr} !== 3'b011) begin
         errors++; $display("FAIL wdog_trip: got %b want 011", {ramREN, dwait, memerr});
      end
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (memerr !== 1'b1) begin
            errors++; $display("FAIL wdog_sticky%0d: got %b want 1", k, memerr);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset_mid();
      dREN = 1; daddr = 32'h500; ramstate = FREE;
      #1;
      @(negedge CLK);
      ramstate = BUSY;
      #1;
      checks++;
      if ({ramREN, memerr} !== 2'b11) begin
         errors++; $display("FAIL rstmid_pre: got %b want 11", {ramREN, memerr});
      end
      #1 nRST = 0;
      #1;
      checks++;
      if ({ramREN, ramWEN, iwait, dwait, memerr, ramaddr} !== {5'b00110, 32'h0}) begin
         errors++; $display("FAIL rstmid_async: got %b/%h want 00110/00000000",
                            {ramREN, ramWEN, iwait, dwait, memerr}, ramaddr);
      end
      dREN = 0;
      @(negedge CLK);
      nRST = 1;
      @(negedge CLK);
      #1;
      checks++;
      if ({ramREN, iwait, dwait, memerr} !== 4'b0110) begin
         errors++; $display("FAIL rstmid_after: got %b want 0110", {ramREN, iwait, dwait, memerr});
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_simultaneous();
      test_starvation();
      test_abort();
      test_watchdog();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
